pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the five-stage MIPS pipeline registers (F/D/E/M/W).
//  - Detects load-use hazards and taken-branch flushes.
//  - Runs the multi-cycle data-memory handshake for the M stage.
//  - Drives the we/clr enables of every pipeline register, including the
//    M->W writeback register.
//  - Keeps a saturating stall-cycle counter and a sticky memory-timeout error.
// PARAMETERS
//  TIMEOUT_CYCLES  64  WAIT cycles without dmem_ready before entering ERROR (>=1)
//  CNT_W           32  width of stall_count
// PORTS
//  clk              in   1      clock; all state updates on rising edge
//  rst              in   1      synchronous reset, active-high
//  rs_d, rt_d       in   5      source register fields of the D-stage instruction
//  mem_read_e       in   1      E-stage instruction is a load
//  reg_write_addr_e in   5      E-stage destination register
//  branch_taken_d   in   1      D-stage branch/jump resolved taken
//  mem_access_m     in   1      M-stage instruction is a load or store
//  dmem_ready       in   1      data memory completes the current access this cycle
//  dmem_req         out  1      data-memory request, held until dmem_ready
//  stall_f, stall_d out  1      hold PC / IF-ID register (we=0)
//  stall_e, stall_m out  1      hold ID-EX / EX-MEM register
//  flush_d, flush_e out  1      clear IF-ID / ID-EX register (bubble)
//  flush_w          out  1      clear MEM-WB register (bubble into W)
//  mem_timeout      out  1      sticky error flag
//  stall_count      out  CNT_W  saturating count of cycles with stall_f=1
// BEHAVIOUR
//  Reset
//  - rst=1 at an edge: state<=IDLE, wait counter<=0, stall_count<=0, mem_timeout<=0.
//  - All combinational outputs are 0 while rst=1.
//  - Reset mid-WAIT drops dmem_req in the reset cycle and aborts the access.
//  FSM states: IDLE, WAIT, ERROR
//  - IDLE:
//    - dmem_req = mem_access_m.
//    - If mem_access_m && !dmem_ready, go to WAIT. A zero-wait access
//      (ready in the same cycle) stays in IDLE with no stall.
//  - WAIT:
//    - dmem_req = 1. Wait counter increments each cycle.
//    - If dmem_ready: go to IDLE and clear the counter. That cycle is unstalled,
//      so the pipeline advances.
//    - Else if counter == TIMEOUT_CYCLES-1: go to ERROR.
//  - ERROR:
//    - dmem_req = 0; mem_timeout = 1; stall_f/d/e/m = 1; flush_w = 1.
//    - Exits only via rst.
//  Memory stall (WAIT with !dmem_ready, or IDLE with mem_access_m && !dmem_ready)
//  - stall_f, stall_d, stall_e and stall_m = 1; flush_w = 1.
//  - Load-use logic and branch flushes are suppressed (flush_d = flush_e = 0).
//  Load-use (only when there is no memory stall)
//  - Hazard = mem_read_e && reg_write_addr_e != 0 &&
//    (reg_write_addr_e == rs_d || reg_write_addr_e == rt_d).
//  - Hazard -> stall_f = stall_d = 1, flush_e = 1, stall_e = stall_m = 0.
//    Exactly one bubble per hazard.
//  Branch
//  - flush_d = branch_taken_d && !stall_d. Any stall wins; the branch is
//    re-evaluated the next cycle.
//  Other rules
//  - Stall and flush outputs are combinational (Mealy on dmem_ready); zero latency.
//  - stall_count increments on every non-reset cycle with stall_f = 1 and holds
//    at 2^CNT_W - 1.
//  - Outputs not named in a rule are 0.
// TESTING
//  1. mem_access_m=1 with dmem_ready=1 in the same cycle -> dmem_req=1, no stall,
//     stall_count stays 0.
//  2. mem_access_m=1, dmem_ready rises after 3 cycles -> stall_f..m=1 and
//     flush_w=1 for 3 cycles, released in the ready cycle, stall_count=3.
//  3. mem_read_e=1, reg_write_addr_e=5, rs_d=5 -> one cycle of stall_f=stall_d=1,
//     flush_e=1; addr 0 -> no stall.
//  4. branch_taken_d=1 coincident with a load-use hazard -> flush_d=0; next cycle,
//     with the hazard gone and the branch still taken -> flush_d=1.
//  5. TIMEOUT_CYCLES=4 with dmem_ready never asserted -> ERROR entered after
//     4 WAIT cycles, mem_timeout=1 and held; rst clears everything.
//  6. CNT_W=3 with 10 stall cycles -> stall_count saturates at 7. rst asserted
//     mid-WAIT -> dmem_req=0 and state IDLE.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for a five-stage MIPS pipeline
//
// Purpose:
//   Generates the we/clr controls of the F/D/E/M/W pipeline registers from
//   load-use hazards, taken branches and a multi-cycle data-memory handshake.
//   Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rs_d, rt_d               D-stage source register fields
//   mem_read_e               E-stage instruction is a load
//   reg_write_addr_e         E-stage destination register
//   branch_taken_d           D-stage branch/jump resolved taken
//   mem_access_m             M-stage instruction is a load or store
//   dmem_ready               data memory completes the access this cycle
//   dmem_req                 data-memory request
//   stall_f/d/e/m            hold PC, IF-ID, ID-EX, EX-MEM registers
//   flush_d/e/w              clear IF-ID, ID-EX, MEM-WB registers
//   mem_timeout              sticky memory-timeout error
//   stall_count              saturating count of cycles with stall_f=1

module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             mem_read_e,
    input  logic [4:0]       reg_write_addr_e,
    input  logic             branch_taken_d,
    input  logic             mem_access_m,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    // Wait counter only has to reach TIMEOUT_CYCLES-1.
    localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic                mem_stall;
    logic                load_use;

    assign load_use = mem_read_e && (reg_write_addr_e != 5'd0) &&
                      ((reg_write_addr_e == rs_d) || (reg_write_addr_e == rt_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        mem_stall = 1'b0;
        dmem_req  = 1'b0;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dmem_req = mem_access_m;
                // A zero-wait access completes in place without stalling.
                if (mem_access_m && !dmem_ready) begin
                    mem_stall = 1'b1;
                    state_d   = ST_WAIT;
                    wcnt_d    = '0;
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    // Completion cycle is unstalled so the M-stage result advances.
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                mem_stall = 1'b1;
                timeout_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Memory stall freezes everything up to M and bubbles W; load-use and
        // branch handling are ignored until the access resolves.
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end

        // A stalled branch is re-evaluated next cycle rather than flushed now.
        flush_d = branch_taken_d && !stall_d;

        if (rst) begin
            dmem_req = 1'b0;
            stall_f  = 1'b0;
            stall_d  = 1'b0;
            stall_e  = 1'b0;
            stall_m  = 1'b0;
            flush_d  = 1'b0;
            flush_e  = 1'b0;
            flush_w  = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       mem_read_e;
    logic [4:0] reg_write_addr_e;
    logic       branch_taken_d;
    logic       mem_access_m;
    logic       dmem_ready;

    logic        b_dmem_req, b_stall_f, b_stall_d, b_stall_e, b_stall_m;
    logic        b_flush_d, b_flush_e, b_flush_w, b_mem_timeout;
    logic [31:0] b_stall_count;

    logic        s_dmem_req, s_stall_f, s_stall_d, s_stall_e, s_stall_m;
    logic        s_flush_d, s_flush_e, s_flush_w, s_mem_timeout;
    logic [2:0]  s_stall_count;

    int n_checks;
    int n_pass;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d),
        .mem_read_e(mem_read_e), .reg_write_addr_e(reg_write_addr_e),
        .branch_taken_d(branch_taken_d), .mem_access_m(mem_access_m),
        .dmem_ready(dmem_ready), .dmem_req(b_dmem_req),
        .stall_f(b_stall_f), .stall_d(b_stall_d), .stall_e(b_stall_e), .stall_m(b_stall_m),
        .flush_d(b_flush_d), .flush_e(b_flush_e), .flush_w(b_flush_w),
        .mem_timeout(b_mem_timeout), .stall_count(b_stall_count)
    );

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d),
        .mem_read_e(mem_read_e), .reg_write_addr_e(reg_write_addr_e),
        .branch_taken_d(branch_taken_d), .mem_access_m(mem_access_m),
        .dmem_ready(dmem_ready), .dmem_req(s_dmem_req),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
        .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_w(s_flush_w),
        .mem_timeout(s_mem_timeout), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        rs_d = '0; rt_d = '0; mem_read_e = 1'b0; reg_write_addr_e = '0;
        branch_taken_d = 1'b0; mem_access_m = 1'b0; dmem_ready = 1'b0;

        // Reset: combinational outputs forced low while rst=1
        tick();
        mem_access_m = 1'b1; branch_taken_d = 1'b1;
        #1;
        check_eq("rst_dmem_req", b_dmem_req, 0);
        check_eq("rst_stall_f", b_stall_f, 0);
        check_eq("rst_flush_d", b_flush_d, 0);
        tick();
        rst = 1'b0; mem_access_m = 1'b0; branch_taken_d = 1'b0;
        #1;
        check_eq("rst_stall_count", b_stall_count, 0);
        check_eq("rst_mem_timeout", s_mem_timeout, 0);
        check_eq("rst_idle_stall_f", b_stall_f, 0);

        // 1: zero-wait access
        mem_access_m = 1'b1; dmem_ready = 1'b1;
        #1;
        check_eq("zw_dmem_req", b_dmem_req, 1);
        check_eq("zw_stall_f", b_stall_f, 0);
        check_eq("zw_flush_w", b_flush_w, 0);
        tick();
        check_eq("zw_stall_count", b_stall_count, 0);
        mem_access_m = 1'b0; dmem_ready = 1'b0;
        tick();

        // 2: three wait cycles then ready
        mem_access_m = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("ws%0d_stall_f", i), b_stall_f, 1);
            check_eq($sformatf("ws%0d_stall_e", i), b_stall_e, 1);
            check_eq($sformatf("ws%0d_stall_m", i), b_stall_m, 1);
            check_eq($sformatf("ws%0d_flush_w", i), b_flush_w, 1);
            check_eq($sformatf("ws%0d_dmem_req", i), b_dmem_req, 1);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        check_eq("ws_rdy_stall_f", b_stall_f, 0);
        check_eq("ws_rdy_stall_m", b_stall_m, 0);
        check_eq("ws_rdy_flush_w", b_flush_w, 0);
        check_eq("ws_rdy_dmem_req", b_dmem_req, 1);
        tick();
        mem_access_m = 1'b0; dmem_ready = 1'b0;
        #1;
        check_eq("ws_stall_count", b_stall_count, 3);
        check_eq("ws_small_count", s_stall_count, 3);
        check_eq("ws_idle_stall_f", b_stall_f, 0);

        // 3: load-use hazard
        mem_read_e = 1'b1; reg_write_addr_e = 5'd5; rs_d = 5'd5; rt_d = 5'd0;
        #1;
        check_eq("lu_rs_stall_f", b_stall_f, 1);
        check_eq("lu_rs_stall_d", b_stall_d, 1);
        check_eq("lu_rs_flush_e", b_flush_e, 1);
        check_eq("lu_rs_stall_e", b_stall_e, 0);
        check_eq("lu_rs_stall_m", b_stall_m, 0);
        check_eq("lu_rs_flush_w", b_flush_w, 0);
        tick();
        rs_d = 5'd0; rt_d = 5'd5;
        #1;
        check_eq("lu_rt_stall_d", b_stall_d, 1);
        check_eq("lu_rt_flush_e", b_flush_e, 1);
        tick();
        reg_write_addr_e = 5'd0; rs_d = 5'd0; rt_d = 5'd0;
        #1;
        check_eq("lu_r0_stall_f", b_stall_f, 0);
        check_eq("lu_r0_flush_e", b_flush_e, 0);
        mem_read_e = 1'b0; reg_write_addr_e = 5'd5; rs_d = 5'd5;
        #1;
        check_eq("lu_noload_stall_f", b_stall_f, 0);
        tick();
        check_eq("lu_stall_count", b_stall_count, 5);

        // 4: branch vs stalls
        mem_read_e = 1'b1; reg_write_addr_e = 5'd7; rs_d = 5'd7; rt_d = 5'd0;
        branch_taken_d = 1'b1;
        #1;
        check_eq("br_hz_flush_d", b_flush_d, 0);
        check_eq("br_hz_stall_d", b_stall_d, 1);
        tick();
        mem_read_e = 1'b0;
        #1;
        check_eq("br_ok_flush_d", b_flush_d, 1);
        check_eq("br_ok_stall_d", b_stall_d, 0);
        mem_read_e = 1'b1; mem_access_m = 1'b1; dmem_ready = 1'b0;
        #1;
        check_eq("br_mem_flush_d", b_flush_d, 0);
        check_eq("br_mem_flush_e", b_flush_e, 0);
        check_eq("br_mem_stall_e", b_stall_e, 1);
        mem_read_e = 1'b0; mem_access_m = 1'b0; branch_taken_d = 1'b0;
        reg_write_addr_e = 5'd0; rs_d = 5'd0;

        // 5/6: timeout with TIMEOUT_CYCLES=4, saturation with CNT_W=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_access_m = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("to_pre_mem_timeout", s_mem_timeout, 0);
        check_eq("to_pre_stall_f", s_stall_f, 1);
        check_eq("to_pre_dmem_req", s_dmem_req, 1);
        tick();
        check_eq("to_mem_timeout", s_mem_timeout, 1);
        check_eq("to_dmem_req", s_dmem_req, 0);
        check_eq("to_stall_m", s_stall_m, 1);
        check_eq("to_flush_w", s_flush_w, 1);
        check_eq("to_big_mem_timeout", b_mem_timeout, 0);
        check_eq("to_big_dmem_req", b_dmem_req, 1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("sat_big_count", b_stall_count, 10);
        check_eq("sat_small_count", s_stall_count, 7);
        dmem_ready = 1'b1;
        #1;
        check_eq("to_sticky_mem_timeout", s_mem_timeout, 1);
        check_eq("to_sticky_stall_f", s_stall_f, 1);
        check_eq("to_big_rdy_stall_f", b_stall_f, 0);
        tick();
        dmem_ready = 1'b0;
        tick();
        // Big instance is back in WAIT; reset mid-access.
        rst = 1'b1;
        #1;
        check_eq("rw_dmem_req", b_dmem_req, 0);
        check_eq("rw_stall_f", b_stall_f, 0);
        check_eq("rw_small_flush_w", s_flush_w, 0);
        tick();
        rst = 1'b0; mem_access_m = 1'b0;
        #1;
        check_eq("rw_idle_dmem_req", b_dmem_req, 0);
        check_eq("rw_idle_stall_f", b_stall_f, 0);
        check_eq("rw_mem_timeout", s_mem_timeout, 0);
        check_eq("rw_small_count", s_stall_count, 0);
        check_eq("rw_big_count", b_stall_count, 0);
        check_eq("rw_small_stall_f", s_stall_f, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
